regfile_port_arbiter: RTL and testbench

- Shares one lockstep register file (one read port plus a three-channel write port: en/index/data) between two clients, C0 and C1.
- Each client has its own read request/response channels and its own write channel.
- The block arbitrates the read port and the write port independently.
- It also sequences the register file's write-token stream: every register-file read dequeues one write token, so the block supplies a bubble token (en=0) whenever no client write is pending.

---
 rtl/regfile_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares one lockstep register file (one read port and
// one en/index/data write-token port) between two clients, C0 and C1.
// Read and write ports are arbitrated independently. Once a winner stalls,
// its grant is locked until its transfer completes. When no client write is
// pending, a bubble token (en=0) keeps the write-token stream flowing.
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, the favoured client
// alternates after each completed transfer. When undefined, C0 always wins
// an unlocked contest.
module regfile_port_arbiter #(
  parameter int width = 32,
  parameter int n     = 5
) (
  input  logic             CLK,
  input  logic             RST,
  // client 0 read
  input  logic [n-1:0]     C0_RD_REQ_WRITE,
  input  logic             C0_RD_REQ_WRITE_VALID,
  output logic             C0_RD_REQ_WRITE_CONSUMED,
  output logic [width-1:0] C0_RD_RESP_READ,
  output logic             C0_RD_RESP_READ_VALID,
  input  logic             C0_RD_RESP_READ_CONSUMED,
  // client 1 read
  input  logic [n-1:0]     C1_RD_REQ_WRITE,
  input  logic             C1_RD_REQ_WRITE_VALID,
  output logic             C1_RD_REQ_WRITE_CONSUMED,
  output logic [width-1:0] C1_RD_RESP_READ,
  output logic             C1_RD_RESP_READ_VALID,
  input  logic             C1_RD_RESP_READ_CONSUMED,
  // client 0 write
  input  logic [n-1:0]     C0_WR_INDEX_WRITE,
  input  logic [width-1:0] C0_WR_DATA_WRITE,
  input  logic             C0_WR_VALID,
  output logic             C0_WR_CONSUMED,
  // client 1 write
  input  logic [n-1:0]     C1_WR_INDEX_WRITE,
  input  logic [width-1:0] C1_WR_DATA_WRITE,
  input  logic             C1_WR_VALID,
  output logic             C1_WR_CONSUMED,
  // register file read port
  output logic [n-1:0]     RF_READ_REQ_WRITE,
  output logic             RF_READ_REQ_WRITE_VALID,
  input  logic             RF_READ_REQ_WRITE_CONSUMED,
  input  logic [width-1:0] RF_READ_RESP_READ,
  input  logic             RF_READ_RESP_READ_VALID,
  output logic             RF_READ_RESP_READ_CONSUMED,
  // register file write-token port
  output logic             RF_WRITE_EN_WRITE,
  output logic [n-1:0]     RF_WRITE_INDEX_WRITE,
  output logic [width-1:0] RF_WRITE_DATA_WRITE,
  output logic             RF_WRITE_VALID,
  input  logic             RF_WRITE_CONSUMED
);

  // Winner encoding: 0 = C0, 1 = C1.
  logic rd_lock, rd_gnt, rd_win, rd_win_vld, rd_done;
  logic wr_lock, wr_gnt, wr_win, wr_win_vld, wr_done;
`ifdef ARB_ROUND_ROBIN_EN
  logic rd_ptr, wr_ptr;
`endif

  // Read winner: a held grant first, then the lone valid client, then the favoured one.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_win = 1'b0;
    if (rd_lock)
      rd_win = rd_gnt;
    else if (C0_RD_REQ_WRITE_VALID && C1_RD_REQ_WRITE_VALID)
`ifdef ARB_ROUND_ROBIN_EN
      rd_win = rd_ptr;
`else
      rd_win = 1'b0;
`endif
    else
      rd_win = C1_RD_REQ_WRITE_VALID;
  end

  // Read routing: the winner talks to the register file and the loser sees idle handshakes.
  always_comb begin
    rd_win_vld                 = rd_win ? C1_RD_REQ_WRITE_VALID : C0_RD_REQ_WRITE_VALID;
    RF_READ_REQ_WRITE          = rd_win ? C1_RD_REQ_WRITE : C0_RD_REQ_WRITE;
    RF_READ_REQ_WRITE_VALID    = !RST && rd_win_vld;
    C0_RD_REQ_WRITE_CONSUMED   = !RST && !rd_win && RF_READ_REQ_WRITE_CONSUMED;
    C1_RD_REQ_WRITE_CONSUMED   = !RST &&  rd_win && RF_READ_REQ_WRITE_CONSUMED;
    C0_RD_RESP_READ            = RF_READ_RESP_READ;
    C1_RD_RESP_READ            = RF_READ_RESP_READ;
    C0_RD_RESP_READ_VALID      = !RST && !rd_win && RF_READ_RESP_READ_VALID;
    C1_RD_RESP_READ_VALID      = !RST &&  rd_win && RF_READ_RESP_READ_VALID;
    RF_READ_RESP_READ_CONSUMED = !RST && (rd_win ? C1_RD_RESP_READ_CONSUMED
                                                 : C0_RD_RESP_READ_CONSUMED);
    rd_done                    = RF_READ_RESP_READ_VALID && RF_READ_RESP_READ_CONSUMED;
  end

  // Read state: release and rotate on completion, lock the winner on a stall.
  // NOTE: state registers use non-blocking assignments and a synchronous reset
  // checked first, so a reset mid-lock simply drops the lock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_lock <= 1'b0;
      rd_gnt  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rd_ptr  <= 1'b0;
`endif
    end else if (rd_done) begin
      rd_lock <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rd_ptr  <= ~rd_win;
`endif
    end else if (rd_win_vld) begin
      rd_lock <= 1'b1;
      rd_gnt  <= rd_win;
    end
  end

  // Write winner: same priority rule as the read side, on the write channels.
  always_comb begin
    wr_win = 1'b0;
    if (wr_lock)
      wr_win = wr_gnt;
    else if (C0_WR_VALID && C1_WR_VALID)
`ifdef ARB_ROUND_ROBIN_EN
      wr_win = wr_ptr;
`else
      wr_win = 1'b0;
`endif
    else
      wr_win = C1_WR_VALID;
  end

  // Write token: a real write from the winner, or a zeroed bubble when nothing is pending.
  always_comb begin
    wr_win_vld           = wr_win ? C1_WR_VALID : C0_WR_VALID;
    RF_WRITE_VALID       = !RST;
    RF_WRITE_EN_WRITE    = wr_win_vld;
    RF_WRITE_INDEX_WRITE = '0;
    RF_WRITE_DATA_WRITE  = '0;
    if (wr_win_vld) begin
      RF_WRITE_INDEX_WRITE = wr_win ? C1_WR_INDEX_WRITE : C0_WR_INDEX_WRITE;
      RF_WRITE_DATA_WRITE  = wr_win ? C1_WR_DATA_WRITE  : C0_WR_DATA_WRITE;
    end
    C0_WR_CONSUMED = !RST && !wr_win && RF_WRITE_CONSUMED && C0_WR_VALID;
    C1_WR_CONSUMED = !RST &&  wr_win && RF_WRITE_CONSUMED && C1_WR_VALID;
    wr_done        = RF_WRITE_CONSUMED && wr_win_vld;
  end

  // Write state: a consumed real write releases and rotates; a consumed bubble changes nothing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_lock <= 1'b0;
      wr_gnt  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      wr_ptr  <= 1'b0;
`endif
    end else if (wr_done) begin
      wr_lock <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      wr_ptr  <= ~wr_win;
`endif
    end else if (wr_win_vld) begin
      wr_lock <= 1'b1;
      wr_gnt  <= wr_win;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed stimulus pushes expected read
// responses and write tokens into queues, and a monitor pops and compares
// them whenever a client transfer occurs. A small register-file model
// answers reads in the same cycle and applies consumed write tokens.
module tb_regfile_port_arbiter;

  localparam int W = 32;
  localparam int N = 5;

  typedef struct {
    logic         cl;
    logic [W-1:0] data;
  } rd_exp_t;

  typedef struct {
    logic         cl;
    logic [N-1:0] idx;
    logic [W-1:0] data;
  } wr_exp_t;

  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0] c_rd_idx  [2];
  logic [1:0]   c_rd_vld;
  logic [1:0]   c_resp_cons;
  logic [N-1:0] c_wr_idx  [2];
  logic [W-1:0] c_wr_data [2];
  logic [1:0]   c_wr_vld;
  logic         rf_rd_rdy, rf_wr_rdy;

  logic [1:0]   rd_req_cons, resp_vld, wr_cons;
  logic [W-1:0] resp_data [2];
  logic [N-1:0] rf_rd_idx;
  logic         rf_rd_vld, rf_resp_cons;
  logic         rf_wr_en, rf_wr_vld;
  logic [N-1:0] rf_wr_idx;
  logic [W-1:0] rf_wr_data;

  logic [W-1:0] arr [32];
  logic [W-1:0] rf_resp_data;
  logic         rf_resp_vld;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Register-file model: zero-latency read, write token applied at the edge.
  assign rf_resp_data = arr[rf_rd_idx];
  assign rf_resp_vld  = rf_rd_vld && rf_rd_rdy;

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) arr[i] <= 32'hA500_0000 + i;
    end else if (rf_wr_vld && rf_wr_rdy && rf_wr_en) begin
      arr[rf_wr_idx] <= rf_wr_data;
    end
  end

  regfile_port_arbiter #(.width(W), .n(N)) dut (
    .CLK                        (CLK),
    .RST                        (RST),
    .C0_RD_REQ_WRITE            (c_rd_idx[0]),
    .C0_RD_REQ_WRITE_VALID      (c_rd_vld[0]),
    .C0_RD_REQ_WRITE_CONSUMED   (rd_req_cons[0]),
    .C0_RD_RESP_READ            (resp_data[0]),
    .C0_RD_RESP_READ_VALID      (resp_vld[0]),
    .C0_RD_RESP_READ_CONSUMED   (c_resp_cons[0]),
    .C1_RD_REQ_WRITE            (c_rd_idx[1]),
    .C1_RD_REQ_WRITE_VALID      (c_rd_vld[1]),
    .C1_RD_REQ_WRITE_CONSUMED   (rd_req_cons[1]),
    .C1_RD_RESP_READ            (resp_data[1]),
    .C1_RD_RESP_READ_VALID      (resp_vld[1]),
    .C1_RD_RESP_READ_CONSUMED   (c_resp_cons[1]),
    .C0_WR_INDEX_WRITE          (c_wr_idx[0]),
    .C0_WR_DATA_WRITE           (c_wr_data[0]),
    .C0_WR_VALID                (c_wr_vld[0]),
    .C0_WR_CONSUMED             (wr_cons[0]),
    .C1_WR_INDEX_WRITE          (c_wr_idx[1]),
    .C1_WR_DATA_WRITE           (c_wr_data[1]),
    .C1_WR_VALID                (c_wr_vld[1]),
    .C1_WR_CONSUMED             (wr_cons[1]),
    .RF_READ_REQ_WRITE          (rf_rd_idx),
    .RF_READ_REQ_WRITE_VALID    (rf_rd_vld),
    .RF_READ_REQ_WRITE_CONSUMED (rf_rd_rdy),
    .RF_READ_RESP_READ          (rf_resp_data),
    .RF_READ_RESP_READ_VALID    (rf_resp_vld),
    .RF_READ_RESP_READ_CONSUMED (rf_resp_cons),
    .RF_WRITE_EN_WRITE          (rf_wr_en),
    .RF_WRITE_INDEX_WRITE       (rf_wr_idx),
    .RF_WRITE_DATA_WRITE        (rf_wr_data),
    .RF_WRITE_VALID             (rf_wr_vld),
    .RF_WRITE_CONSUMED          (rf_wr_rdy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_rd(input logic cl, input logic [W-1:0] data);
    rd_exp_t e;
    e.cl = cl;
    e.data = data;
    rd_q.push_back(e);
  endtask

  task automatic push_wr(input logic cl, input logic [N-1:0] idx, input logic [W-1:0] data);
    wr_exp_t e;
    e.cl = cl;
    e.idx = idx;
    e.data = data;
    wr_q.push_back(e);
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_rf_rd_vld"},   rf_rd_vld,    1'b0);
    check({tag, "_rf_wr_vld"},   rf_wr_vld,    1'b0);
    check({tag, "_rf_resp_cons"}, rf_resp_cons, 1'b0);
    check({tag, "_rd_req_cons"}, rd_req_cons,  2'b00);
    check({tag, "_resp_vld"},    resp_vld,     2'b00);
    check({tag, "_wr_cons"},     wr_cons,      2'b00);
  endtask

  // Monitor: every client-side transfer pops and compares the next expectation.
  initial begin
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge CLK);
      for (int c = 0; c < 2; c++) begin
        if (resp_vld[c] && c_resp_cons[c]) begin
          if (rd_q.size() == 0) begin
            check("rd_expected_pending", 0, 1);
          end else begin
            re = rd_q.pop_front();
            check("rd_client", c, re.cl);
            check("rd_data", resp_data[c], re.data);
          end
        end
      end
      if (wr_cons != 2'b00) begin
        if (wr_q.size() == 0) begin
          check("wr_expected_pending", 0, 1);
        end else begin
          we = wr_q.pop_front();
          check("wr_client", wr_cons, we.cl ? 2'b10 : 2'b01);
          check("wr_en",     rf_wr_en,   1'b1);
          check("wr_index",  rf_wr_idx,  we.idx);
          check("wr_data",   rf_wr_data, we.data);
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    c_rd_vld = '0; c_resp_cons = '0; c_wr_vld = '0;
    c_rd_idx[0] = '0; c_rd_idx[1] = '0;
    c_wr_idx[0] = '0; c_wr_idx[1] = '0;
    c_wr_data[0] = '0; c_wr_data[1] = '0;
    rf_rd_rdy = 1'b1; rf_wr_rdy = 1'b1;
    step(); step();

    // Reset: everything quiet, then an idle bubble token once released.
    #1 check_all_quiet("reset");
    RST = 1'b0;
    #1;
    check("idle_wr_vld", rf_wr_vld,  1'b1);
    check("idle_wr_en",  rf_wr_en,   1'b0);
    check("idle_wr_idx", rf_wr_idx,  5'd0);
    check("idle_wr_data", rf_wr_data, 32'h0);
    check("idle_rd_vld", rf_rd_vld,  1'b0);
    step();

    // Both clients read continuously (3 from C0, 7 from C1).
    c_rd_vld = 2'b11; c_rd_idx[0] = 5'd3; c_rd_idx[1] = 5'd7; c_resp_cons = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
    push_rd(0, 32'hA500_0003); push_rd(1, 32'hA500_0007);
    push_rd(0, 32'hA500_0003); push_rd(1, 32'hA500_0007);
`else
    for (int i = 0; i < 4; i++) push_rd(0, 32'hA500_0003);
`endif
    repeat (4) step();
    c_rd_vld = 2'b00;
    step();

    // C1 granted alone, stalls two cycles while C0 waits.
    c_rd_vld = 2'b10; c_resp_cons = 2'b00;
    push_rd(1, 32'hA500_0007); push_rd(0, 32'hA500_0003);
    #1 check("stall_c1_idx_1", rf_rd_idx, 5'd7);
    step();
    c_rd_vld = 2'b11; c_resp_cons = 2'b01;
    #1;
    check("stall_c1_idx_2", rf_rd_idx, 5'd7);
    check("stall_c0_blocked_2", rd_req_cons[0], 1'b0);
    step();
    c_resp_cons = 2'b11;
    #1;
    check("stall_c1_idx_3", rf_rd_idx, 5'd7);
    check("stall_c0_blocked_3", rd_req_cons[0], 1'b0);
    step();
    c_rd_vld = 2'b01;
    #1;
    check("stall_c0_idx_4", rf_rd_idx, 5'd3);
    check("stall_c0_cons_4", rd_req_cons[0], 1'b1);
    step();
    c_rd_vld = 2'b00;
    step();

    // C0 reads alone with no writes: bubble tokens every cycle.
    c_rd_vld = 2'b01; c_rd_idx[0] = 5'd10;
    for (int i = 0; i < 3; i++) begin
      push_rd(0, 32'hA500_000A);
      #1;
      check("bubble_vld", rf_wr_vld, 1'b1);
      check("bubble_en",  rf_wr_en,  1'b0);
      step();
    end
    c_rd_vld = 2'b00;
    step();

    // Simultaneous writes to index 5: C0 first, then C1; read back C1's value.
    c_wr_vld = 2'b11; c_wr_idx[0] = 5'd5; c_wr_idx[1] = 5'd5;
    c_wr_data[0] = 32'h0000_AAAA; c_wr_data[1] = 32'h0000_5555;
    push_wr(0, 5'd5, 32'h0000_AAAA); push_wr(1, 5'd5, 32'h0000_5555);
    #1;
    check("wr_same_c0_first", wr_cons, 2'b01);
    step();
    c_wr_vld = 2'b10;
    #1 check("wr_same_c1_second", wr_cons, 2'b10);
    step();
    c_wr_vld = 2'b00;
    c_rd_vld = 2'b01; c_rd_idx[0] = 5'd5;
    push_rd(0, 32'h0000_5555);
    step();
    c_rd_vld = 2'b00;
    step();

    // Write stall: C1 locks the write port while the register file is busy.
    c_wr_vld = 2'b10; c_wr_idx[1] = 5'd9; c_wr_data[1] = 32'h0000_1234; rf_wr_rdy = 1'b0;
    push_wr(1, 5'd9, 32'h0000_1234); push_wr(0, 5'd9, 32'h0000_9999);
    #1;
    check("wr_stall_not_cons", wr_cons, 2'b00);
    check("wr_stall_en", rf_wr_en, 1'b1);
    check("wr_stall_idx", rf_wr_idx, 5'd9);
    step();
    c_wr_vld = 2'b11; c_wr_idx[0] = 5'd9; c_wr_data[0] = 32'h0000_9999; rf_wr_rdy = 1'b1;
    #1;
    check("wr_lock_c1_wins", wr_cons, 2'b10);
    check("wr_lock_data", rf_wr_data, 32'h0000_1234);
    step();
    c_wr_vld = 2'b01;
    #1 check("wr_after_lock_c0", wr_cons, 2'b01);
    step();
    c_wr_vld = 2'b00;
    c_rd_vld = 2'b01; c_rd_idx[0] = 5'd9;
    push_rd(0, 32'h0000_9999);
    step();
    c_rd_vld = 2'b00;
    step();

    // Reset while C1 holds the read lock: quiet outputs, then C0 favoured.
    c_rd_vld = 2'b10; c_rd_idx[0] = 5'd3; c_rd_idx[1] = 5'd7; c_resp_cons = 2'b00;
    step();
    c_rd_vld = 2'b11; c_resp_cons = 2'b11; RST = 1'b1;
    #1 check_all_quiet("midlock_rst");
    step();
    RST = 1'b0;
    push_rd(0, 32'hA500_0003);
    #1 check("post_rst_c0_idx", rf_rd_idx, 5'd3);
    step();
    c_rd_vld = 2'b10;
    push_rd(1, 32'hA500_0007);
    step();
    c_rd_vld = 2'b00;
    step(); step();

    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
